sound_mixer_mc: RTL and testbench



---
 rtl/sound_mixer_mc.sv | 238 +++++++++++++++++++++++
 tb/tb_sound_mixer_mc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_mixer_mc.sv
`timescale 1ns/1ps
// sound_mixer_mc
// Time-multiplexed stereo mixer: CHANNELS inputs, each with its own L/R volume
// and mute, summed into WIDTH+4 bit accumulators, then scaled by a per-side
// master volume and saturated to WIDTH bits. Configured through an indexed
// 8-bit register file.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ce_sample             one-cycle strobe starting a mix
//   in_l, in_r            packed signed inputs, channel c at [c*WIDTH +: WIDTH]
//   cfg_we/cfg_rd         register write / read strobes
//   cfg_index/cfg_wdata   register index / write data
//   cfg_rdata             registered read data
//   out_l, out_r          mixed samples (held between pulses)
//   out_valid             one-cycle pulse when out_l/out_r update
//   busy                  high while a mix is in progress
module sound_mixer_mc #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce_sample,
  input  logic [CHANNELS*WIDTH-1:0] in_l,
  input  logic [CHANNELS*WIDTH-1:0] in_r,
  input  logic                      cfg_we,
  input  logic                      cfg_rd,
  input  logic [7:0]                cfg_index,
  input  logic [7:0]                cfg_wdata,
  output logic [7:0]                cfg_rdata,
  output logic [WIDTH-1:0]          out_l,
  output logic [WIDTH-1:0]          out_r,
  output logic                      out_valid,
  output logic                      busy
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = WIDTH + 4;  // accumulator width
  localparam int PW = WIDTH + 6;  // pre-saturation width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    MASTER = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Live register file
  logic [CHANNELS-1:0][4:0] vol_l_q, vol_l_d, vol_r_q, vol_r_d;
  logic [CHANNELS-1:0]      mute_l_q, mute_l_d, mute_r_q, mute_r_d;
  logic [4:0]               mvol_l_q, mvol_l_d, mvol_r_q, mvol_r_d;
  logic                     ovr_q, ovr_d;
  logic [7:0]               rdata_q, rd_val;

  // Shadow copies used by the mix in progress
  logic [CHANNELS-1:0][4:0] sh_vol_l_q, sh_vol_r_q;
  logic [CHANNELS-1:0]      sh_mute_l_q, sh_mute_r_q;
  logic [4:0]               sh_mvol_l_q, sh_mvol_r_q;
  logic [CHANNELS*WIDTH-1:0] sin_l_q, sin_r_q;

  logic [CW-1:0]            ch_q;
  logic [AW-1:0]            acc_l_q, acc_r_q;
  logic [PW-1:0]            pre_l_q, pre_r_q;
  logic [WIDTH-1:0]         hold_l_q, hold_r_q;

  // Register writes and reads (reads see pre-write values)
  always_comb begin
    vol_l_d  = vol_l_q;
    vol_r_d  = vol_r_q;
    mute_l_d = mute_l_q;
    mute_r_d = mute_r_q;
    mvol_l_d = mvol_l_q;
    mvol_r_d = mvol_r_q;
    rd_val   = '0;
    if (cfg_we) begin
      if (cfg_index == 8'h00) begin
        vol_l_d  = '1;
        vol_r_d  = '1;
        mute_l_d = '0;
        mute_r_d = '0;
        mvol_l_d = '1;
        mvol_r_d = '1;
      end else if (cfg_index == 8'h01) begin
        mvol_l_d = cfg_wdata[4:0];
      end else if (cfg_index == 8'h02) begin
        mvol_r_d = cfg_wdata[4:0];
      end
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (cfg_index == 8'(16 + 2*c)) begin
          vol_l_d[c]  = cfg_wdata[4:0];
          mute_l_d[c] = cfg_wdata[7];
        end
        if (cfg_index == 8'(17 + 2*c)) begin
          vol_r_d[c]  = cfg_wdata[4:0];
          mute_r_d[c] = cfg_wdata[7];
        end
      end
    end
    if (cfg_index == 8'h01) rd_val = {3'b000, mvol_l_q};
    if (cfg_index == 8'h02) rd_val = {3'b000, mvol_r_q};
    if (cfg_index == 8'h0F) rd_val = {6'b0, (state_q != IDLE), ovr_q};
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (cfg_index == 8'(16 + 2*c)) rd_val = {mute_l_q[c], 2'b00, vol_l_q[c]};
      if (cfg_index == 8'(17 + 2*c)) rd_val = {mute_r_q[c], 2'b00, vol_r_q[c]};
    end
  end

  // A new overrun in the same cycle as a status read survives the clear
  always_comb begin
    ovr_d = ovr_q;
    if (cfg_rd && cfg_index == 8'h0F) ovr_d = 1'b0;
    if (ce_sample && state_q != IDLE) ovr_d = 1'b1;
  end

  // Channel product: (sample * (vol+1)) >>> 5, zero when muted
  logic [WIDTH-1:0]   smp_l, smp_r;
  logic [6:0]         g_l, g_r, mg_l, mg_r;
  logic [WIDTH+6:0]   pf_l, pf_r;
  logic [WIDTH+1:0]   ps_l, ps_r;
  logic [AW+6:0]      mf_l, mf_r;

  always_comb begin
    smp_l = sin_l_q[int'(ch_q)*WIDTH +: WIDTH];
    smp_r = sin_r_q[int'(ch_q)*WIDTH +: WIDTH];
    g_l   = {2'b00, sh_vol_l_q[ch_q]} + 7'd1;
    g_r   = {2'b00, sh_vol_r_q[ch_q]} + 7'd1;
    // Operands sign-extended to the product width so an unsigned multiply
    // yields the correct two's-complement low bits.
    pf_l  = {{7{smp_l[WIDTH-1]}}, smp_l} * {{WIDTH{1'b0}}, g_l};
    pf_r  = {{7{smp_r[WIDTH-1]}}, smp_r} * {{WIDTH{1'b0}}, g_r};
    ps_l  = sh_mute_l_q[ch_q] ? '0 : pf_l[WIDTH+6:5];
    ps_r  = sh_mute_r_q[ch_q] ? '0 : pf_r[WIDTH+6:5];
    mg_l  = {2'b00, sh_mvol_l_q} + 7'd1;
    mg_r  = {2'b00, sh_mvol_r_q} + 7'd1;
    mf_l  = {{7{acc_l_q[AW-1]}}, acc_l_q} * {{AW{1'b0}}, mg_l};
    mf_r  = {{7{acc_r_q[AW-1]}}, acc_r_q} * {{AW{1'b0}}, mg_r};
  end

  // Saturation: value fits when bits [PW-1:WIDTH-1] are all equal
  logic [WIDTH-1:0] sat_l, sat_r;
  always_comb begin
    sat_l = pre_l_q[WIDTH-1:0];
    sat_r = pre_r_q[WIDTH-1:0];
    if (!(&pre_l_q[PW-1:WIDTH-1] || ~|pre_l_q[PW-1:WIDTH-1]))
      sat_l = pre_l_q[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    if (!(&pre_r_q[PW-1:WIDTH-1] || ~|pre_r_q[PW-1:WIDTH-1]))
      sat_r = pre_r_q[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ce_sample) state_d = ACCUM;
      ACCUM:   if (ch_q == CW'(CHANNELS-1)) state_d = MASTER;
      MASTER:  state_d = OUT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vol_l_q     <= '1;
      vol_r_q     <= '1;
      mute_l_q    <= '0;
      mute_r_q    <= '0;
      mvol_l_q    <= '1;
      mvol_r_q    <= '1;
      ovr_q       <= 1'b0;
      rdata_q     <= '0;
      sh_vol_l_q  <= '1;
      sh_vol_r_q  <= '1;
      sh_mute_l_q <= '0;
      sh_mute_r_q <= '0;
      sh_mvol_l_q <= '1;
      sh_mvol_r_q <= '1;
      sin_l_q     <= '0;
      sin_r_q     <= '0;
      ch_q        <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      pre_l_q     <= '0;
      pre_r_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
    end else begin
      state_q  <= state_d;
      vol_l_q  <= vol_l_d;
      vol_r_q  <= vol_r_d;
      mute_l_q <= mute_l_d;
      mute_r_q <= mute_r_d;
      mvol_l_q <= mvol_l_d;
      mvol_r_q <= mvol_r_d;
      ovr_q    <= ovr_d;
      if (cfg_rd) rdata_q <= rd_val;
      case (state_q)
        IDLE: if (ce_sample) begin
          sh_vol_l_q  <= vol_l_q;
          sh_vol_r_q  <= vol_r_q;
          sh_mute_l_q <= mute_l_q;
          sh_mute_r_q <= mute_r_q;
          sh_mvol_l_q <= mvol_l_q;
          sh_mvol_r_q <= mvol_r_q;
          sin_l_q     <= in_l;
          sin_r_q     <= in_r;
          acc_l_q     <= '0;
          acc_r_q     <= '0;
          ch_q        <= '0;
        end
        ACCUM: begin
          acc_l_q <= acc_l_q + {{2{ps_l[WIDTH+1]}}, ps_l};
          acc_r_q <= acc_r_q + {{2{ps_r[WIDTH+1]}}, ps_r};
          ch_q    <= ch_q + CW'(1);
        end
        MASTER: begin
          pre_l_q <= mf_l[AW+6:5];
          pre_r_q <= mf_r[AW+6:5];
        end
        default: begin
          hold_l_q <= sat_l;
          hold_r_q <= sat_r;
        end
      endcase
    end
  end

  // Saturated result is presented during the OUT cycle itself and latched
  // into the hold registers at its end, so the outputs change exactly with
  // the out_valid pulse and hold afterwards.
  assign out_l     = (state_q == OUT) ? sat_l : hold_l_q;
  assign out_r     = (state_q == OUT) ? sat_r : hold_r_q;
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign cfg_rdata = rdata_q;

endmodule

// File: tb/tb_sound_mixer_mc.sv
`timescale 1ns/1ps
module tb_sound_mixer_mc;

  localparam int CH = 4;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ce_sample = 1'b0;
  logic [CH*W-1:0] in_l = '0;
  logic [CH*W-1:0] in_r = '0;
  logic            cfg_we = 1'b0;
  logic            cfg_rd = 1'b0;
  logic [7:0]      cfg_index = '0;
  logic [7:0]      cfg_wdata = '0;
  logic [7:0]      cfg_rdata;
  logic [W-1:0]    out_l, out_r;
  logic            out_valid, busy;

  sound_mixer_mc #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ce_sample(ce_sample),
    .in_l(in_l), .in_r(in_r),
    .cfg_we(cfg_we), .cfg_rd(cfg_rd), .cfg_index(cfg_index),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int unsigned  cyc;
  } mix_exp_t;

  mix_exp_t    mq[$];
  logic [7:0]  rq[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic        rd_d1 = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_d1 <= cfg_rd & rst_n;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops expected mixes on out_valid and expected read data after a read
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (mq.size() == 0) begin
        check("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        mix_exp_t e;
        e = mq.pop_front();
        check("out_l", 32'(out_l), 32'(e.l));
        check("out_r", 32'(out_r), 32'(e.r));
        check("valid_cycle", cyc, e.cyc);
      end
    end
    if (rd_d1) begin
      if (rq.size() == 0) begin
        check("unexpected_read", 32'd1, 32'd0);
      end else begin
        logic [7:0] er;
        er = rq.pop_front();
        check("cfg_rdata", 32'(cfg_rdata), 32'(er));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] idx, input logic [7:0] d);
    cfg_we = 1'b1; cfg_index = idx; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] idx, input logic [7:0] exp);
    cfg_rd = 1'b1; cfg_index = idx;
    rq.push_back(exp);
    tick();
    cfg_rd = 1'b0;
  endtask

  task automatic wr_rd(input logic [7:0] idx, input logic [7:0] d, input logic [7:0] exp);
    cfg_we = 1'b1; cfg_rd = 1'b1; cfg_index = idx; cfg_wdata = d;
    rq.push_back(exp);
    tick();
    cfg_we = 1'b0; cfg_rd = 1'b0;
  endtask

  task automatic start_mix(input logic [W-1:0] el, input logic [W-1:0] er);
    mix_exp_t e;
    e.l = el; e.r = er; e.cyc = cyc + 6;
    mq.push_back(e);
    ce_sample = 1'b1;
    tick();
    ce_sample = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while ((busy !== 1'b0 || mq.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    tick();
    if (n >= 40) begin
      check("wait_idle_timeout", 32'd1, 32'd0);
      mq.delete();
    end
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] l, input logic [W-1:0] r);
    in_l[c*W +: W] = l;
    in_r[c*W +: W] = r;
  endtask

  initial begin
    #12;
    rst_n = 1'b1;
    tick();
    // Reset state
    check("reset_out_l", 32'(out_l), 32'h0);
    check("reset_out_r", 32'(out_r), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rd(8'h10, 8'h1F);
    rd(8'h0F, 8'h00);

    // Single channel at unity
    set_ch(0, 16'h1000, 16'h0000);
    start_mix(16'h1000, 16'h0000);
    wait_idle();

    // Positive and negative saturation
    for (int c = 0; c < CH; c++) set_ch(c, 16'h7000, 16'h0000);
    start_mix(16'h7FFF, 16'h0000);
    wait_idle();
    for (int c = 0; c < CH; c++) set_ch(c, 16'h8000, 16'h0000);
    start_mix(16'h8000, 16'h0000);
    wait_idle();

    // Channel volume, mute, master volume
    in_l = '0; in_r = '0;
    wr(8'h12, 8'h0F);
    set_ch(1, 16'h2000, 16'h0000);
    start_mix(16'h1000, 16'h0000);
    wait_idle();
    wr(8'h12, 8'h8F);
    rd(8'h12, 8'h8F);
    start_mix(16'h0000, 16'h0000);
    wait_idle();
    wr(8'h02, 8'h07);
    set_ch(0, 16'h0800, 16'h4000);
    start_mix(16'h0800, 16'h1000);
    wait_idle();

    // Register file: global reset write, out-of-range indices, write+read same cycle
    wr(8'h00, 8'h55);
    rd(8'h12, 8'h1F);
    rd(8'h02, 8'h1F);
    rd(8'h00, 8'h00);
    wr(8'h18, 8'h05);
    rd(8'h18, 8'h00);
    rd(8'h03, 8'h00);
    wr_rd(8'h01, 8'h05, 8'h1F);
    rd(8'h01, 8'h05);
    wr(8'h00, 8'h00);

    // Floor behaviour of the arithmetic shift at minimum volume
    in_l = '0; in_r = '0;
    wr(8'h10, 8'h00);
    wr(8'h11, 8'h00);
    set_ch(0, 16'hFFFF, 16'h001F);
    start_mix(16'hFFFF, 16'h0000);
    wait_idle();
    wr(8'h00, 8'h00);

    // Overrun: second strobe during a mix is ignored
    in_l = '0; in_r = '0;
    set_ch(0, 16'h0100, 16'h0000);
    start_mix(16'h0100, 16'h0000);
    tick();
    ce_sample = 1'b1;
    tick();
    ce_sample = 1'b0;
    wait_idle();
    rd(8'h0F, 8'h01);
    rd(8'h0F, 8'h00);

    // Shadow registers: a write during a mix only affects the next mix
    set_ch(0, 16'h2000, 16'h0000);
    start_mix(16'h2000, 16'h0000);
    tick();
    wr(8'h10, 8'h0F);
    wait_idle();
    start_mix(16'h1000, 16'h0000);
    wait_idle();

    // Reset mid-mix: mix abandoned, no pulse
    ce_sample = 1'b1;
    tick();
    ce_sample = 1'b0;
    check("busy_during_mix", 32'(busy), 32'h1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_out_l", 32'(out_l), 32'h0);
    check("rst_out_r", 32'(out_r), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    repeat (3) tick();
    #2;
    rst_n = 1'b1;
    repeat (8) tick();
    rd(8'h10, 8'h1F);
    tick();
    tick();

    check("mix_queue_empty", 32'(mq.size()), 32'h0);
    check("read_queue_empty", 32'(rq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
